// File: rtl/acia_tx_pkg.sv
// Shared ACIA definitions: FSM state encodings, register field decodes,
// oversampling constant and small decode helpers.
package acia_tx_pkg;

    localparam int          OVERSAMPLE = 16;
    localparam logic [3:0]  TICK_LAST  = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } acia_state_e;

    localparam logic [1:0] WL_8 = 2'b00;
    localparam logic [1:0] WL_7 = 2'b01;
    localparam logic [1:0] WL_6 = 2'b10;
    localparam logic [1:0] WL_5 = 2'b11;

    localparam logic [1:0] PMC_ODD   = 2'b00;
    localparam logic [1:0] PMC_EVEN  = 2'b01;
    localparam logic [1:0] PMC_MARK  = 2'b10;
    localparam logic [1:0] PMC_SPACE = 2'b11;

    // Index of the last data bit sent for a given word length.
    function automatic logic [2:0] wl_last_bit(input logic [1:0] wl);
        case (wl)
            WL_8:    return 3'd7;
            WL_7:    return 3'd6;
            WL_6:    return 3'd5;
            WL_5:    return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic parity_bit(input logic acc, input logic [1:0] pmc);
        case (pmc)
            PMC_ODD:   return ~acc;
            PMC_EVEN:  return acc;
            PMC_MARK:  return 1'b1;
            PMC_SPACE: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/acia_tx_if.sv
// CPU-side transmit holding-register port of the ACIA.
interface acia_tx_if;
    logic [7:0] TXDATA;
    logic       TXLOAD;
    logic       TXEMPTY;

    modport master (output TXDATA, output TXLOAD, input TXEMPTY);
    modport slave  (input TXDATA, input TXLOAD, output TXEMPTY);
endinterface

// File: rtl/acia_sync2.sv
// Two-flop synchroniser with a configurable reset value; shared by the
// ACIA transmit and receive blocks.
module acia_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/acia_tx.sv
// 6551-style ACIA transmitter: PHI2 holding register handed to a BCLK (16x)
// serialiser by a req/ack toggle pair. Build option ACIA_TX_CTS_EN holds frame start while CTSB=1.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a pending byte
// ST_START  | start bit (0)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit
// ST_STOP   | first stop bit (1)
// ST_STOP2  | second stop bit (1)
module acia_tx
    import acia_tx_pkg::*;
(
    input  logic        BCLK,
    input  logic        RESET,
    input  logic        PHI2,
    acia_tx_if.slave    cpu,
    output logic        TX,
    output logic        TXBUSY,
    input  logic [1:0]  R_WL,
    input  logic        R_PME,
    input  logic [1:0]  R_PMC,
    input  logic        R_SBN,
    input  logic        CTSB
);
    logic [7:0]  r_hold;
    logic        r_req;
    logic        r_empty;
    logic        w_ack_sync;
    logic        w_req_sync;
    logic        w_cts_ok;

    acia_state_e r_state, w_state_nxt;
    logic [3:0]  r_tick, w_tick_nxt;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic        r_ack, w_ack_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_tick_done;

    acia_sync2 #(.RST_VAL(1'b0)) u_sync_ack (
        .i_clk(PHI2), .i_rst_b(RESET), .i_d(r_ack), .o_q(w_ack_sync)
    );

    always_ff @(posedge PHI2 or negedge RESET) begin
        if (!RESET) begin
            r_hold  <= 8'h00;
            r_req   <= 1'b0;
            r_empty <= 1'b1;
        end else if (cpu.TXLOAD && r_empty) begin
            r_hold  <= cpu.TXDATA;
            r_req   <= ~r_req;
            r_empty <= 1'b0;
        end else if (!r_empty && (w_ack_sync == r_req)) begin
            r_empty <= 1'b1;
        end
    end

    assign cpu.TXEMPTY = r_empty;

    acia_sync2 #(.RST_VAL(1'b0)) u_sync_req (
        .i_clk(BCLK), .i_rst_b(RESET), .i_d(r_req), .o_q(w_req_sync)
    );

`ifdef ACIA_TX_CTS_EN
    logic w_cts_sync;
    acia_sync2 #(.RST_VAL(1'b1)) u_sync_cts (
        .i_clk(BCLK), .i_rst_b(RESET), .i_d(CTSB), .o_q(w_cts_sync)
    );
    assign w_cts_ok = ~w_cts_sync;
`else
    logic w_unused_ctsb;
    assign w_unused_ctsb = CTSB;
    assign w_cts_ok      = 1'b1;
`endif

    assign w_tick_done = (r_tick == 4'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = w_tick_done ? TICK_LAST : r_tick - 4'd1;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_ack_nxt    = r_ack;
        case (r_state)
            ST_IDLE: begin
                w_tick_nxt = TICK_LAST;
                if ((w_req_sync != r_ack) && w_cts_ok) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = r_hold;
                    w_ack_nxt    = w_req_sync;
                    w_par_nxt    = 1'b0;
                    w_bitcnt_nxt = 3'd0;
                end
            end
            ST_START: begin
                if (w_tick_done) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick_done) begin
                    w_par_nxt   = r_par ^ r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    // A 3-bit counter always wraps onto the last index, so a
                    // word-length change mid-frame cannot strand the FSM here.
                    if (r_bitcnt == wl_last_bit(R_WL)) begin
                        w_state_nxt = R_PME ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick_done) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick_done) w_state_nxt = (R_SBN && !R_PME) ? ST_STOP2 : ST_IDLE;
            end
            ST_STOP2: begin
                if (w_tick_done) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // TX and TXBUSY are registered from the next state so the line is glitch-free.
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = parity_bit(w_par_nxt, R_PMC);
            default:   w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_tick   <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_ack    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_ack    <= w_ack_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign TX     = r_tx;
    assign TXBUSY = r_busy;
endmodule

// File: tb/tb_acia_tx.sv
// Self-checking bench for acia_tx: expected serial bits are queued at load
// time and compared mid-bit as the frame is shifted out.
module tb_acia_tx;
    import acia_tx_pkg::*;

    logic       BCLK  = 1'b0;
    logic       PHI2  = 1'b0;
    logic       RESET = 1'b0;
    logic       TX;
    logic       TXBUSY;
    logic [1:0] R_WL  = 2'b00;
    logic       R_PME = 1'b0;
    logic [1:0] R_PMC = 2'b00;
    logic       R_SBN = 1'b0;
    logic       CTSB  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_q[$];

    acia_tx_if cpu_if ();

    acia_tx dut (
        .BCLK(BCLK), .RESET(RESET), .PHI2(PHI2), .cpu(cpu_if.slave),
        .TX(TX), .TXBUSY(TXBUSY), .R_WL(R_WL), .R_PME(R_PME),
        .R_PMC(R_PMC), .R_SBN(R_SBN), .CTSB(CTSB)
    );

    always #5 BCLK = ~BCLK;
    always #8 PHI2 = ~PHI2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame builder working from the current register fields.
    task automatic push_frame(input logic [7:0] d, output int len);
        int   nbits;
        logic acc;
        int   cnt;
        nbits = 8 - int'(R_WL);
        acc   = 1'b0;
        exp_q.push_back(1'b0);
        cnt = 1;
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back(d[i]);
            acc = acc ^ d[i];
            cnt++;
        end
        if (R_PME) begin
            case (R_PMC)
                2'b00:   exp_q.push_back(~acc);
                2'b01:   exp_q.push_back(acc);
                2'b10:   exp_q.push_back(1'b1);
                default: exp_q.push_back(1'b0);
            endcase
            cnt++;
        end
        exp_q.push_back(1'b1);
        cnt++;
        if (R_SBN && !R_PME) begin
            exp_q.push_back(1'b1);
            cnt++;
        end
        len = cnt * OVERSAMPLE;
    endtask

    task automatic cpu_load(input logic [7:0] d);
        @(negedge PHI2);
        cpu_if.TXDATA = d;
        cpu_if.TXLOAD = 1'b1;
        @(negedge PHI2);
        cpu_if.TXLOAD = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int exp_len,
                             output int wait_cnt, output logic empty_at_stop);
        int   n;
        logic exp_bit;
        wait_cnt      = 0;
        empty_at_stop = 1'b0;
        while (TXBUSY !== 1'b1 && wait_cnt < 300) begin
            @(negedge BCLK);
            wait_cnt++;
        end
        chk({tag, "_start_seen"}, 32'(wait_cnt < 300), 32'd1);
        n = 0;
        while (TXBUSY === 1'b1 && n < 400) begin
            if (n % OVERSAMPLE == OVERSAMPLE / 2) begin
                exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                chk($sformatf("%s_bit%0d", tag, n / OVERSAMPLE), 32'(TX), 32'(exp_bit));
            end
            if (n == exp_len - OVERSAMPLE / 2) empty_at_stop = cpu_if.TXEMPTY;
            @(negedge BCLK);
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    initial begin
        int   len1, len2, w1, w2, cnt;
        logic es1, es2;

        cpu_if.TXDATA = 8'h00;
        cpu_if.TXLOAD = 1'b0;
        repeat (3) @(negedge BCLK);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(TXBUSY), 32'd0);
        chk("rst_empty", 32'(cpu_if.TXEMPTY), 32'd1);
        RESET = 1'b1;
        repeat (4) @(negedge BCLK);

        // 8N1, 0x55
        R_WL = 2'b00; R_PME = 1'b0; R_PMC = 2'b00; R_SBN = 1'b0;
        push_frame(8'h55, len1);
        cpu_load(8'h55);
        chk("t1_empty_after_load", 32'(cpu_if.TXEMPTY), 32'd0);
        run_frame("t1", len1, w1, es1);
        chk("t1_latency_ok", 32'((w1 >= 1) && (w1 <= 5)), 32'd1);
        chk("t1_empty_before_stop_end", 32'(es1), 32'd1);
        chk("t1_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge BCLK);

        // 7E1, 0x41
        R_WL = 2'b01; R_PME = 1'b1; R_PMC = 2'b01; R_SBN = 1'b0;
        push_frame(8'h41, len1);
        chk("t2_model_len", 32'(len1), 32'd160);
        cpu_load(8'h41);
        run_frame("t2", 160, w1, es1);
        chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge BCLK);

        // 5N2, 0x1F
        R_WL = 2'b11; R_PME = 1'b0; R_PMC = 2'b00; R_SBN = 1'b1;
        push_frame(8'h1F, len1);
        cpu_load(8'h1F);
        run_frame("t3", 128, w1, es1);
        chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge BCLK);

        // Back-to-back 0xA5 / 0x3C, third load while full must be dropped
        R_WL = 2'b00; R_PME = 1'b0; R_PMC = 2'b00; R_SBN = 1'b0;
        push_frame(8'hA5, len1);
        cpu_load(8'hA5);
        fork
            begin
                run_frame("b2b_f1", len1, w1, es1);
                run_frame("b2b_f2", 160, w2, es2);
            end
            begin
                cnt = 0;
                while (cpu_if.TXEMPTY !== 1'b1 && cnt < 100) begin
                    @(negedge PHI2);
                    cnt++;
                end
                chk("b2b_empty_seen", 32'(cnt < 100), 32'd1);
                push_frame(8'h3C, len2);
                cpu_load(8'h3C);
                chk("b2b_empty_after_2nd", 32'(cpu_if.TXEMPTY), 32'd0);
                cpu_load(8'h77);
                chk("b2b_empty_after_3rd", 32'(cpu_if.TXEMPTY), 32'd0);
            end
        join
        chk("b2b_idle_gap", 32'(w2), 32'd1);
        chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
        cnt = 0;
        repeat (64) begin
            @(negedge BCLK);
            if (TXBUSY !== 1'b0) cnt++;
        end
        chk("b2b_no_third_frame", 32'(cnt), 32'd0);
        chk("b2b_empty_final", 32'(cpu_if.TXEMPTY), 32'd1);

`ifdef ACIA_TX_CTS_EN
        CTSB = 1'b1;
        repeat (4) @(negedge BCLK);
        push_frame(8'h12, len1);
        cpu_load(8'h12);
        cnt = 0;
        repeat (64) begin
            @(negedge BCLK);
            if (TXBUSY !== 1'b0 || TX !== 1'b1) cnt++;
        end
        chk("cts_held_idle", 32'(cnt), 32'd0);
        chk("cts_empty_held", 32'(cpu_if.TXEMPTY), 32'd0);
        CTSB = 1'b0;
        run_frame("cts", len1, w1, es1);
        chk("cts_start_within_4", 32'(w1 <= 4), 32'd1);
        chk("cts_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge BCLK);
`endif

        // Reset in the middle of data bit 3 of a 0x00 frame
        cpu_load(8'h00);
        cnt = 0;
        while (TXBUSY !== 1'b1 && cnt < 300) begin
            @(negedge BCLK);
            cnt++;
        end
        chk("rst_mid_start_seen", 32'(cnt < 300), 32'd1);
        repeat (4 * OVERSAMPLE + OVERSAMPLE / 2) @(negedge BCLK);
        chk("rst_mid_bit3_low", 32'(TX), 32'd0);
        RESET = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(TX), 32'd1);
        chk("rst_mid_busy", 32'(TXBUSY), 32'd0);
        chk("rst_mid_empty", 32'(cpu_if.TXEMPTY), 32'd1);
        repeat (3) @(negedge BCLK);
        RESET = 1'b1;
        repeat (4) @(negedge BCLK);
        push_frame(8'h80, len1);
        cpu_load(8'h80);
        run_frame("post_rst", len1, w1, es1);
        chk("post_rst_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
